// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA sequencer: a CPU write to DMA_REG_ADDR halts the CPU and copies
// one 256-byte page to OAM_PORT_ADDR. Define DMA_ALIGN_EN to add the parity-aligned ALIGN state.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_PORT_ADDR = 16'h2004
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CPU_TICK,
  input  logic [15:0] CPU_ADDR,
  input  logic [7:0]  CPU_DATA_OUT,
  input  logic        CPU_RW_n,
  input  logic [7:0]  BUS_DATA_IN,
  output logic        CPU_ENABLE,
  output logic [15:0] BUS_ADDR,
  output logic [7:0]  BUS_DATA_OUT,
  output logic        BUS_RW_n,
  output logic        DMA_ACTIVE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] latch_q, latch_d;
`ifdef DMA_ALIGN_EN
  logic       parity_q, parity_d;
`endif

  // Every state change and data capture is gated by the CPU bus-cycle strobe.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    latch_d = latch_q;
`ifdef DMA_ALIGN_EN
    parity_d = parity_q ^ CPU_TICK;
`endif
    if (CPU_TICK) begin
      case (state_q)
        S_IDLE: begin
          if (CPU_ADDR == DMA_REG_ADDR && !CPU_RW_n) begin
            page_d  = CPU_DATA_OUT;
            idx_d   = 8'd0;
            state_d = S_HALT;
          end
        end
        S_HALT: begin
`ifdef DMA_ALIGN_EN
          state_d = parity_q ? S_READ : S_ALIGN;
`else
          state_d = S_READ;
`endif
        end
        S_ALIGN: state_d = S_READ;
        S_READ: begin
          latch_d = BUS_DATA_IN;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          if (idx_q == 8'hFF) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outside IDLE the CPU is frozen and the bus is driven by the sequencer.
  always_comb begin
    CPU_ENABLE   = 1'b0;
    DMA_ACTIVE   = 1'b1;
    BUS_ADDR     = CPU_ADDR;
    BUS_DATA_OUT = CPU_DATA_OUT;
    BUS_RW_n     = 1'b1;
    case (state_q)
      S_IDLE: begin
        CPU_ENABLE = CPU_TICK;
        DMA_ACTIVE = 1'b0;
        BUS_RW_n   = CPU_RW_n;
      end
      S_READ: BUS_ADDR = {page_q, idx_q};
      S_WRITE: begin
        BUS_ADDR     = OAM_PORT_ADDR;
        BUS_DATA_OUT = latch_q;
        BUS_RW_n     = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      page_q   <= 8'd0;
      idx_q    <= 8'd0;
      latch_q  <= 8'd0;
`ifdef DMA_ALIGN_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      latch_q  <= latch_d;
`ifdef DMA_ALIGN_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: stimulus queues expected reads, OAM writes
// and stall lengths; a negedge monitor pops and compares on each CPU tick.
module tb_oam_dma_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CPU_TICK;
  logic [15:0] CPU_ADDR;
  logic [7:0]  CPU_DATA_OUT;
  logic        CPU_RW_n;
  logic [7:0]  BUS_DATA_IN;
  logic        CPU_ENABLE;
  logic [15:0] BUS_ADDR;
  logic [7:0]  BUS_DATA_OUT;
  logic        BUS_RW_n;
  logic        DMA_ACTIVE;

  oam_dma_ctrl dut (
    .CLK(CLK), .RESET(RESET), .CPU_TICK(CPU_TICK), .CPU_ADDR(CPU_ADDR),
    .CPU_DATA_OUT(CPU_DATA_OUT), .CPU_RW_n(CPU_RW_n), .BUS_DATA_IN(BUS_DATA_IN),
    .CPU_ENABLE(CPU_ENABLE), .BUS_ADDR(BUS_ADDR), .BUS_DATA_OUT(BUS_DATA_OUT),
    .BUS_RW_n(BUS_RW_n), .DMA_ACTIVE(DMA_ACTIVE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    if (a[15:8] == 8'h02) return a[7:0] ^ 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  assign BUS_DATA_IN = mem_val(BUS_ADDR);

  logic [7:0]  wr_q[$];
  logic [15:0] rd_q[$];
  int          stall_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          oam_wr_cnt = 0;
  int          stall_cnt = 0;
  bit          tb_par = 1'b0;
  bit          in_dma = 1'b0;
  bit          first_rd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // Monitor: passthrough while idle, scoreboard pops on DMA ticks.
  always @(negedge CLK) begin
    if (RESET) begin
      in_dma    = 1'b0;
      stall_cnt = 0;
    end else if (!DMA_ACTIVE) begin
      check("idle_passthru", {BUS_ADDR, BUS_DATA_OUT, BUS_RW_n, CPU_ENABLE},
            {CPU_ADDR, CPU_DATA_OUT, CPU_RW_n, CPU_TICK});
      if (CPU_TICK && in_dma) begin
        in_dma = 1'b0;
        if (stall_q.size() != 0) check("stall_ticks", stall_cnt, stall_q.pop_front());
        else unexpected("stall_ticks", stall_cnt);
      end
    end else if (CPU_TICK) begin
      if (!in_dma) begin
        in_dma    = 1'b1;
        stall_cnt = 0;
        first_rd  = 1'b1;
      end
      stall_cnt++;
      check("dma_cpu_enable", CPU_ENABLE, 0);
      if (!BUS_RW_n) begin
        if (BUS_ADDR == 16'h2004 && wr_q.size() != 0) begin
          check("oam_wr_data", BUS_DATA_OUT, wr_q.pop_front());
          oam_wr_cnt++;
        end else begin
          unexpected("dma_wr_addr", BUS_ADDR);
        end
      end else if (BUS_ADDR != CPU_ADDR) begin
        if (rd_q.size() != 0) check("dma_rd_addr", BUS_ADDR, rd_q.pop_front());
        else unexpected("dma_rd_addr", BUS_ADDR);
`ifdef DMA_ALIGN_EN
        if (first_rd) check("first_read_parity", tb_par, 0);
`endif
        first_rd = 1'b0;
      end
    end
  end

  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic rw);
    CPU_ADDR     = a;
    CPU_DATA_OUT = d;
    CPU_RW_n     = rw;
    CPU_TICK     = 1'b1;
    @(posedge CLK);
    #1;
    tb_par   = ~tb_par;
    CPU_TICK = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic start_dma(input logic [7:0] page);
    logic [15:0] a;
    for (int i = 0; i < 256; i++) begin
      a = {page, 8'(i)};
      rd_q.push_back(a);
      wr_q.push_back(mem_val(a));
    end
`ifdef DMA_ALIGN_EN
    stall_q.push_back(tb_par ? 514 : 513);
`else
    stall_q.push_back(513);
`endif
    cyc(16'h4014, page, 1'b0);
    check("halt_active", DMA_ACTIVE, 1);
  endtask

  task automatic run_dma();
    int n = 0;
    while (DMA_ACTIVE && n < 600) begin
      cyc(16'h8000, 8'h00, 1'b1);
      n++;
    end
    if (n >= 600) unexpected("dma_timeout", n);
    cyc(16'h8000, 8'h00, 1'b1);
    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    RESET        = 1'b1;
    CPU_TICK     = 1'b0;
    CPU_ADDR     = 16'h8000;
    CPU_DATA_OUT = 8'h00;
    CPU_RW_n     = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    check("reset_dma_active", DMA_ACTIVE, 0);
    check("reset_cpu_enable", CPU_ENABLE, 0);
    check("reset_bus", {BUS_ADDR, BUS_RW_n}, {16'h8000, 1'b1});

    repeat (3) cyc(16'h8000, 8'h00, 1'b1);
    cyc(16'h0000, 8'h55, 1'b0);

    cyc(16'h4013, 8'h12, 1'b0);
    cyc(16'h4015, 8'h12, 1'b0);
    cyc(16'h4014, 8'h12, 1'b1);
    check("no_trigger", DMA_ACTIVE, 0);

    // Trigger on an odd tick, then on an even tick.
    if (!tb_par) cyc(16'h8000, 8'h00, 1'b1);
    start_dma(8'h02);
    run_dma();
    if (tb_par) cyc(16'h8000, 8'h00, 1'b1);
    start_dma(8'hFF);
    run_dma();

    // Abort after 100 OAM writes.
    base = oam_wr_cnt;
    start_dma(8'h02);
    n = 0;
    while (oam_wr_cnt < base + 100 && n < 400) begin
      cyc(16'h8000, 8'h00, 1'b1);
      n++;
    end
    check("writes_before_reset", oam_wr_cnt - base, 100);
    RESET = 1'b1;
    #1;
    check("async_reset_active", DMA_ACTIVE, 0);
    check("async_reset_cpu_en", CPU_ENABLE, 0);
    wr_q.delete();
    rd_q.delete();
    stall_q.delete();
    @(negedge CLK);
    #1;
    RESET  = 1'b0;
    tb_par = 1'b0;
    base = oam_wr_cnt;
    repeat (10) cyc(16'h8000, 8'h00, 1'b1);
    check("no_wr_after_reset", oam_wr_cnt - base, 0);
    check("idle_after_reset", DMA_ACTIVE, 0);
    start_dma(8'h02);
    run_dma();

    // Reset coincident with a trigger tick.
    @(posedge CLK);
    #1;
    CPU_ADDR     = 16'h4014;
    CPU_DATA_OUT = 8'h03;
    CPU_RW_n     = 1'b0;
    CPU_TICK     = 1'b1;
    RESET        = 1'b1;
    @(posedge CLK);
    #1;
    RESET    = 1'b0;
    CPU_TICK = 1'b0;
    tb_par   = 1'b0;
    check("reset_beats_trigger", DMA_ACTIVE, 0);
    cyc(16'h8000, 8'h00, 1'b1);
    check("still_idle", DMA_ACTIVE, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
